// File: rtl/instr_mem_pipelined.sv
// Instruction memory for the MIPS datapath.
// After reset it zero-fills itself. It can then be loaded at run time through a streaming
// program port. Fetches use a req/ready handshake and return data after a fixed latency of
// 1 or 2 cycles. Misaligned and out-of-range fetches return a zero word and raise fault flags.
module instr_mem_pipelined #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fault_misalign,
  output logic              fault_range,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic              prog_last,
  output logic              prog_done,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, PROG} state_e;

  state_e            state_q;
  logic [PTR_W-1:0]  wrPtr_q;
  logic              progDone_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              memWe_d;
  logic [DATA_W-1:0] memWdata_d;

  logic              fetchAccept;
  logic [IDX_W-1:0]  fetchIdx;
  logic              fetchMis;
  logic              fetchRng;
  logic [DATA_W-1:0] fetchData;

  logic              pipeValid;
  logic [DATA_W-1:0] pipeData;
  logic              pipeMis;
  logic              pipeRng;

  logic [DATA_W-1:0] instrOut_q;
  logic              instrValid_q;
  logic              faultMis_q;
  logic              faultRng_q;

  // Sequence the memory through clear, idle and program phases.
  // In these phases the write pointer is advanced and the done pulse is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      wrPtr_q    <= '0;
      progDone_q <= 1'b0;
    end else begin
      progDone_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          wrPtr_q <= wrPtr_q + 1'b1;
          if (wrPtr_q == LAST_PTR) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
          end
        end
        IDLE: begin
          if (prog_start) begin
            state_q <= PROG;
            wrPtr_q <= '0;
          end
        end
        PROG: begin
          if (prog_valid) begin
            wrPtr_q <= wrPtr_q + 1'b1;
            if (prog_last || (wrPtr_q == LAST_PTR)) begin
              state_q    <= IDLE;
              progDone_q <= 1'b1;
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Select what, if anything, is written at the write pointer this cycle.
  always_comb begin
    memWe_d    = 1'b0;
    memWdata_d = '0;
    if (!reset) begin
      if (state_q == CLEAR) begin
        memWe_d = 1'b1;
      end else if ((state_q == PROG) && prog_valid) begin
        memWe_d    = 1'b1;
        memWdata_d = prog_wdata;
      end
    end
  end

  // The storage array has no reset; the clear phase zero-fills it instead.
  always_ff @(posedge clk) begin
    if (memWe_d) begin
      mem[wrPtr_q] <= memWdata_d;
    end
  end

  assign fetch_ready = ~reset & (state_q == IDLE) & ~fetch_stall & ~prog_start;
  assign fetchAccept = fetch_req & fetch_ready;
  assign fetchIdx    = fetch_addr[ADDR_W-1:2];
  assign fetchMis    = |fetch_addr[1:0];
  assign fetchRng    = fetchIdx >= DEPTH_IDX;

  // Faulted fetches never touch the array and return a zero word.
  always_comb begin
    fetchData = '0;
    if (!fetchMis && !fetchRng) begin
      fetchData = mem[fetchIdx[PTR_W-1:0]];
    end
  end

  generate
    if (RD_LATENCY == 2) begin : gLat2
      logic              s1Valid_q;
      logic [DATA_W-1:0] s1Data_q;
      logic              s1Mis_q;
      logic              s1Rng_q;

      // Extra stage for the two-cycle configuration; it freezes together with the outputs.
      always_ff @(posedge clk) begin
        if (reset) begin
          s1Valid_q <= 1'b0;
          s1Data_q  <= '0;
          s1Mis_q   <= 1'b0;
          s1Rng_q   <= 1'b0;
        end else if (!fetch_stall) begin
          s1Valid_q <= fetchAccept;
          s1Data_q  <= fetchData;
          s1Mis_q   <= fetchMis;
          s1Rng_q   <= fetchRng;
        end
      end

      assign pipeValid = s1Valid_q;
      assign pipeData  = s1Data_q;
      assign pipeMis   = s1Mis_q;
      assign pipeRng   = s1Rng_q;
    end else begin : gLat1
      assign pipeValid = fetchAccept;
      assign pipeData  = fetchData;
      assign pipeMis   = fetchMis;
      assign pipeRng   = fetchRng;
    end
  endgenerate

  // Output stage: it presents a completing fetch for one cycle. Between fetches, instr_out
  // keeps its last word. All outputs freeze while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      instrOut_q   <= '0;
      instrValid_q <= 1'b0;
      faultMis_q   <= 1'b0;
      faultRng_q   <= 1'b0;
    end else if (!fetch_stall) begin
      instrValid_q <= pipeValid;
      faultMis_q   <= pipeValid & pipeMis;
      faultRng_q   <= pipeValid & pipeRng;
      if (pipeValid) begin
        instrOut_q <= pipeData;
      end
    end
  end

  assign instr_out      = instrOut_q;
  assign instr_valid    = instrValid_q;
  assign fault_misalign = faultMis_q;
  assign fault_range    = faultRng_q;
  assign prog_done      = progDone_q;
  assign busy           = (state_q != IDLE);

endmodule
